gpio_pattern_seq: RTL
=====================

// Module: gpio_pattern_seq
// PURPOSE
//   Parametrised GPIO pattern sequencer core: successor to the single-mode walking-GPIO team
//   project. Advances a pattern on N_GPIO outputs once every `prescaler` milliseconds.
//   Supports four pattern modes, pause/resume and a wrap pulse for the wrapper's RIS bit.
//   Sits behind the Wishbone wrapper, which supplies prescaler/mode and consumes wrap_pulse.
// PARAMETERS
//   N_GPIO      34     number of driven GPIO bits (>=2)
//   PRESC_W     14     width of prescaler (step period in ms)
//   CLK_PER_MS  10000  clk cycles per ms tick (10 MHz clk); >=2
// PORTS
//   clk         in   1        system clock
//   nrst        in   1        asynchronous active-low reset
//   enable      in   1        level: 1 = run sequencer, 0 = idle, gpio cleared
//   stop        in   1        level: 1 = pause (hold gpio, freeze counters)
//   prescaler   in   PRESC_W  step period in ms; 0 treated as 1
//   mode        in   2        00 walk-one, 01 ping-pong, 10 thermometer fill, 11 binary count
//   gpio        out  N_GPIO   pattern output (registered)
//   step_pulse  out  1        1-cycle pulse on each pattern advance
//   wrap_pulse  out  1        1-cycle pulse when pattern returns to its start value
//   busy        out  1        1 in RUN or PAUSE
// BEHAVIOUR
//   Reset: state=IDLE, gpio=0, step_pulse=0, wrap_pulse=0, busy=0, all counters 0.
//   FSM: IDLE -(enable)-> RUN; RUN -(stop)-> PAUSE; PAUSE -(!stop)-> RUN;
//     RUN/PAUSE -(!enable)-> IDLE (enable low has priority over stop).
//   IDLE->RUN cycle: gpio loads start pattern; ms_cnt=0, step_cnt=0; mode and prescaler latched.
//   Start pattern: walk-one/ping-pong = 1 (bit0); thermometer = 1; binary = 0.
//   Timing: ms_cnt counts 0..CLK_PER_MS-1 in RUN; wrap issues ms_tick. step_cnt counts ms_ticks;
//     when step_cnt == max(latched_presc,1)-1 and ms_tick: gpio advances, step_cnt=0.
//     First advance occurs exactly presc*CLK_PER_MS cycles after the load edge.
//   Advance rules (width N_GPIO):
//     walk-one: rotate left; bit N-1 -> bit0 (wrap).
//     ping-pong: shift in dir; dir flips on reaching bit N-1 / bit0; wrap when back at bit0.
//       Period 2N-2 steps. dir resets to up on load.
//     thermometer: gpio = {gpio[N-2:0],1}; all-ones -> 1 (wrap).
//     binary: gpio+1 modulo 2^N; all-ones -> 0 (wrap).
//   step_pulse asserted the cycle after gpio changes is NOT allowed: both pulses are
//     registered with the gpio update (same clk edge). wrap_pulse implies step_pulse.
//   mode/prescaler sampled only at load and at each step boundary; mid-step writes take effect
//     from the next step. Mode change at a boundary reloads that mode's start pattern
//     (no wrap_pulse for that step).
//   PAUSE: gpio, ms_cnt, step_cnt, dir frozen; resume continues the partial period (no restart).
//   stop asserted in IDLE: no effect until enable; enable+stop together -> RUN load then PAUSE
//     next cycle (pattern loaded, frozen).
//   enable low: next edge gpio=0, pulses 0, busy=0; counters cleared.
//   Async reset mid-run: all outputs to reset values immediately, independent of clk.
// TESTING (bench uses CLK_PER_MS=10, N_GPIO=8, PRESC_W=4)
//   1 presc=1, mode=00, enable=1 -> gpio 01,02,04..80,01 every 10 clk; wrap_pulse once per 80 clk.
//   2 presc=3, mode=01 -> 01,02..80,40..02,01 each 30 clk; wrap after 14 steps (420 clk).
//   3 presc=2, mode=10 -> 01,03,07..FF,01 every 20 clk; mode=11 -> 00,01,02.. wrap at FF->00.
//   4 stop=1 for 37 clk mid-step at 4 clk into period -> gpio held; advance 6 clk after stop=0.
//   5 presc=0 behaves as presc=1; presc 1->4 written mid-step -> current step 10 clk, next 40.
//   6 nrst low mid-run (async, between edges) -> gpio=0, busy=0 immediately; enable low -> gpio=0.

Source files
------------

// File: rtl/gpio_pattern_seq.sv
// GPIO pattern sequencer core: drives one of four patterns (walk-one, ping-pong,
// thermometer fill, binary count) on N_GPIO outputs and advances it once every
// `prescaler` milliseconds. It supports pause/resume and emits step and wrap pulses
// that are registered together with the pattern update.
module gpio_pattern_seq #(
  parameter int N_GPIO     = 34,
  parameter int PRESC_W    = 14,
  parameter int CLK_PER_MS = 10000
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               enable,
  input  logic               stop,
  input  logic [PRESC_W-1:0] prescaler,
  input  logic [1:0]         mode,
  output logic [N_GPIO-1:0]  gpio,
  output logic               step_pulse,
  output logic               wrap_pulse,
  output logic               busy
);

  localparam int MS_W = $clog2(CLK_PER_MS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [MS_W-1:0]    ms_cnt;
  logic [PRESC_W-1:0] step_cnt;
  logic [PRESC_W-1:0] presc_l;
  logic [PRESC_W-1:0] step_last;
  logic [1:0]         mode_l;
  logic               down;
  logic               running;
  logic               ms_tick;
  logic               step_due;

  // Binary count starts from zero; every other mode starts with bit 0 set.
  function automatic logic [N_GPIO-1:0] start_pat(input logic [1:0] md);
    return (md == 2'b11) ? '0 : N_GPIO'(1);
  endfunction

  // One pattern advance; returns {wrap, new_down, new_pattern}.
  function automatic logic [N_GPIO+1:0] advance(input logic [N_GPIO-1:0] cur,
                                                 input logic [1:0]        md,
                                                 input logic              dn);
    logic [N_GPIO-1:0] nxt;
    logic              ndn;
    logic              wrap;
    nxt  = cur;
    ndn  = dn;
    wrap = 1'b0;
    case (md)
      2'b00: begin
        nxt  = {cur[N_GPIO-2:0], cur[N_GPIO-1]};
        wrap = cur[N_GPIO-1];
      end
      2'b01: begin
        if (!dn) begin
          nxt = cur << 1;
          if (nxt[N_GPIO-1]) ndn = 1'b1;
        end else begin
          nxt = cur >> 1;
          if (nxt[0]) begin
            ndn  = 1'b0;
            wrap = 1'b1;
          end
        end
      end
      2'b10: begin
        if (&cur) begin
          nxt  = N_GPIO'(1);
          wrap = 1'b1;
        end else begin
          nxt = {cur[N_GPIO-2:0], 1'b1};
        end
      end
      default: begin
        nxt  = cur + 1'b1;
        wrap = &cur;
      end
    endcase
    return {wrap, ndn, nxt};
  endfunction

  // Counters run only while active, enabled and not stopped; this makes stop freeze
  // on the very edge it is seen and lets resume continue the partial period at once.
  assign running   = (state != IDLE) && enable && !stop;
  assign ms_tick   = running && (ms_cnt == MS_W'(CLK_PER_MS - 1));
  assign step_last = (presc_l == '0) ? '0 : presc_l - 1'b1;
  assign step_due  = ms_tick && (step_cnt == step_last);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; enable low takes priority over stop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
               else if (stop) state_nxt = PAUSE;
      PAUSE:   if (!enable) state_nxt = IDLE;
               else if (!stop) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Pattern, timing counters and pulses; mode/prescaler are latched at load and step boundaries.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gpio       <= '0;
      ms_cnt     <= '0;
      step_cnt   <= '0;
      presc_l    <= '0;
      mode_l     <= '0;
      down       <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      if (state == IDLE) begin
        if (enable) begin
          gpio     <= start_pat(mode);
          ms_cnt   <= '0;
          step_cnt <= '0;
          presc_l  <= prescaler;
          mode_l   <= mode;
          down     <= 1'b0;
        end
      end else if (!enable) begin
        gpio     <= '0;
        ms_cnt   <= '0;
        step_cnt <= '0;
        down     <= 1'b0;
      end else if (running) begin
        if (ms_tick) ms_cnt <= '0;
        else         ms_cnt <= ms_cnt + 1'b1;
        if (step_due) begin
          step_cnt   <= '0;
          presc_l    <= prescaler;
          mode_l     <= mode;
          step_pulse <= 1'b1;
          if (mode != mode_l) begin
            gpio <= start_pat(mode);
            down <= 1'b0;
          end else begin
            {wrap_pulse, down, gpio} <= advance(gpio, mode_l, down);
          end
        end else if (ms_tick) begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

endmodule
